// File: rtl/mips_test_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : mips_test_sequencer_if
// Summary  : Core-side bus between the MIPS core and its self-check
//            sequencer: the data-memory write port the sequencer watches and
//            the reset it drives back into the core.
// Revision : 1.0 - initial release
// ============================================================================
interface mips_test_sequencer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              memwrite;
    logic [ADDR_W-1:0] dataadr;
    logic [DATA_W-1:0] writedata;
    logic              dut_reset;

    // Core side: issues stores, receives its reset
    modport master (
        output memwrite,
        output dataadr,
        output writedata,
        input  dut_reset
    );

    // Sequencer side: observes stores, drives the core reset
    modport slave (
        input  memwrite,
        input  dataadr,
        input  writedata,
        output dut_reset
    );
endinterface
`default_nettype wire

// File: rtl/mips_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mips_test_sequencer
// Summary  : Runs NUM_TESTS core programs back to back. Each test holds the
//            core in reset, releases it for a fixed window and passes if the
//            expected {address,data} store is seen inside that window.
//            Expected stores are loaded through the cfg_* port while idle.
// Options  : SEQ_MISMATCH_LOG_EN - capture the first non-matching store of
//            each test on mm_valid/mm_adr/mm_data (otherwise tied to 0).
// Revision : 1.0 - initial release
// ============================================================================
module mips_test_sequencer #(
    parameter int NUM_TESTS     = 13,
    parameter int WINDOW_CYCLES = 100,
    parameter int RESET_CYCLES  = 2,
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    localparam int IDX_W        = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1,
    localparam int COUNT_W      = $clog2(NUM_TESTS + 1)
) (
    input  wire logic              clk,
    input  wire logic              reset_n,
    input  wire logic              start,
    input  wire logic              cfg_we,
    input  wire logic [IDX_W-1:0]  cfg_idx,
    input  wire logic [ADDR_W-1:0] cfg_adr,
    input  wire logic [DATA_W-1:0] cfg_data,
    mips_test_sequencer_if.slave   bus,
    output logic [IDX_W-1:0]       test_idx,
    output logic                   test_done,
    output logic                   test_pass,
    output logic [COUNT_W-1:0]     pass_count,
    output logic [COUNT_W-1:0]     fail_count,
    output logic                   all_done,
    output logic                   mm_valid,
    output logic [ADDR_W-1:0]      mm_adr,
    output logic [DATA_W-1:0]      mm_data
);
    // One timer serves both the reset hold and the run window
    localparam int TIMER_MAX = (WINDOW_CYCLES > RESET_CYCLES) ? WINDOW_CYCLES : RESET_CYCLES;
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RST    = 3'd1,
        S_RUN    = 3'd2,
        S_RESULT = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [TIMER_W-1:0] r_timer;
    logic               r_hit;
    logic [ADDR_W-1:0]  r_exp_adr  [NUM_TESTS];
    logic [DATA_W-1:0]  r_exp_data [NUM_TESTS];

    logic w_idle_or_done;
    logic w_rst_end;
    logic w_run_end;
    logic w_last_test;
    logic w_store_match;
    logic w_cfg_ok;

    assign w_idle_or_done = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_rst_end      = (r_timer == TIMER_W'(RESET_CYCLES - 1));
    assign w_run_end      = (r_timer == TIMER_W'(WINDOW_CYCLES - 1));
    assign w_last_test    = (test_idx == IDX_W'(NUM_TESTS - 1));
    assign w_store_match  = bus.memwrite
                          && (bus.dataadr   == r_exp_adr[test_idx])
                          && (bus.writedata == r_exp_data[test_idx]);
    assign w_cfg_ok       = cfg_we && w_idle_or_done && (32'(cfg_idx) < NUM_TESTS);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and state-decoded outputs; core is held in reset except in RUN
    always_comb begin
        w_state_nxt   = r_state;
        bus.dut_reset = 1'b1;
        all_done      = 1'b0;
        case (r_state)
            S_IDLE:   if (start) w_state_nxt = S_RST;
            S_RST:    if (w_rst_end) w_state_nxt = S_RUN;
            S_RUN: begin
                bus.dut_reset = 1'b0;
                if (w_run_end) w_state_nxt = S_RESULT;
            end
            S_RESULT: w_state_nxt = w_last_test ? S_DONE : S_RST;
            S_DONE: begin
                all_done = 1'b1;
                if (start) w_state_nxt = S_RST;
            end
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Sequencing datapath: timer, sticky hit, result strobe and run counters.
    // The result is registered on the edge entering RESULT so that a store on
    // the last window cycle still counts (hit OR'd with the live match).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_timer    <= '0;
            r_hit      <= 1'b0;
            test_idx   <= '0;
            test_done  <= 1'b0;
            test_pass  <= 1'b0;
            pass_count <= '0;
            fail_count <= '0;
        end else begin
            test_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_timer <= '0;
                    if (start) begin
                        test_idx   <= '0;
                        pass_count <= '0;
                        fail_count <= '0;
                    end
                end
                S_RST: begin
                    r_hit   <= 1'b0;
                    r_timer <= w_rst_end ? '0 : r_timer + 1'b1;
                end
                S_RUN: begin
                    if (w_store_match) r_hit <= 1'b1;
                    if (w_run_end) begin
                        r_timer   <= '0;
                        test_done <= 1'b1;
                        test_pass <= r_hit || w_store_match;
                        if (r_hit || w_store_match) pass_count <= pass_count + 1'b1;
                        else                        fail_count <= fail_count + 1'b1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_RESULT: begin
                    if (!w_last_test) test_idx <= test_idx + 1'b1;
                end
                default: r_timer <= '0;
            endcase
        end
    end

    // Expected-store table; writable only while no run is in progress
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_TESTS; i++) begin
                r_exp_adr[i]  <= '0;
                r_exp_data[i] <= '0;
            end
        end else if (w_cfg_ok) begin
            r_exp_adr[cfg_idx]  <= cfg_adr;
            r_exp_data[cfg_idx] <= cfg_data;
        end
    end

`ifdef SEQ_MISMATCH_LOG_EN
    // Capture the first non-matching store of the current test; cleared per test
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mm_valid <= 1'b0;
            mm_adr   <= '0;
            mm_data  <= '0;
        end else if (r_state == S_RST) begin
            mm_valid <= 1'b0;
            mm_adr   <= '0;
            mm_data  <= '0;
        end else if ((r_state == S_RUN) && bus.memwrite && !w_store_match && !mm_valid) begin
            mm_valid <= 1'b1;
            mm_adr   <= bus.dataadr;
            mm_data  <= bus.writedata;
        end
    end
`else
    assign mm_valid = 1'b0;
    assign mm_adr   = '0;
    assign mm_data  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mips_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_test_sequencer
// Summary  : Directed self-checking bench for mips_test_sequencer with three
//            test slots. A core stub replays scheduled stores inside each run
//            window; expected per-test results are queued when a test's
//            stimulus is scheduled and compared on each test_done strobe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_test_sequencer;
    localparam int NT     = 3;
    localparam int WIN    = 100;
    localparam int RSTC   = 2;
    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int IW     = 2;
    localparam int CW     = 2;
    localparam int PERIOD = RSTC + WIN + 1;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic          cfg_we;
    logic [IW-1:0] cfg_idx;
    logic [AW-1:0] cfg_adr;
    logic [DW-1:0] cfg_data;
    logic [IW-1:0] test_idx;
    logic          test_done;
    logic          test_pass;
    logic [CW-1:0] pass_count;
    logic [CW-1:0] fail_count;
    logic          all_done;
    logic          mm_valid;
    logic [AW-1:0] mm_adr;
    logic [DW-1:0] mm_data;

    mips_test_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) core_bus ();

    mips_test_sequencer #(
        .NUM_TESTS    (NT),
        .WINDOW_CYCLES(WIN),
        .RESET_CYCLES (RSTC),
        .ADDR_W       (AW),
        .DATA_W       (DW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_adr   (cfg_adr),
        .cfg_data  (cfg_data),
        .bus       (core_bus),
        .test_idx  (test_idx),
        .test_done (test_done),
        .test_pass (test_pass),
        .pass_count(pass_count),
        .fail_count(fail_count),
        .all_done  (all_done),
        .mm_valid  (mm_valid),
        .mm_adr    (mm_adr),
        .mm_data   (mm_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Stub events: kind 0 = core store, 1 = cfg write, 2 = start pulse
    typedef struct {
        int            kind;
        int            cyc;
        int            idx;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
    } ev_t;

    typedef struct {
        logic          pass;
        logic [CW-1:0] pc;
        logic [CW-1:0] fc;
        logic [IW-1:0] idx;
        logic          mmv;
        logic [AW-1:0] mma;
        logic [DW-1:0] mmd;
    } exp_t;

    ev_t           evs[$];
    exp_t          sb[$];
    logic [AW-1:0] m_adr [NT];
    logic [DW-1:0] m_dat [NT];
    int            m_pc;
    int            m_fc;
    int            last_done;
    int            n_vec = 0;
    int            n_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic void add_ev(input int kind, input int cyc, input int idx,
                                   input logic [AW-1:0] a, input logic [DW-1:0] d);
        ev_t ev;
        ev.kind = kind;
        ev.cyc  = cyc;
        ev.idx  = idx;
        ev.adr  = a;
        ev.dat  = d;
        evs.push_back(ev);
    endfunction

    task automatic cfg_write(input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cfg_we   = 1'b1;
        cfg_idx  = IW'(idx);
        cfg_adr  = a;
        cfg_data = d;
        tick();
        cfg_we   = 1'b0;
        if (idx < NT) begin
            m_adr[idx] = a;
            m_dat[idx] = d;
        end
    endtask

    task automatic start_run();
        int n;
        start = 1'b1;
        tick();
        start = 1'b0;
        m_pc      = 0;
        m_fc      = 0;
        last_done = -1;
        check("start_clears_pass", pass_count, 0);
        check("start_clears_fail", fail_count, 0);
        check("start_idx", test_idx, 0);
        check("start_all_done", all_done, 0);
        check("start_dut_reset", core_bus.dut_reset, 1);
        n = 0;
        while (core_bus.dut_reset === 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("start_to_run_cycles", n, RSTC);
    endtask

    // Schedule one test: predict its result, replay queued events over the
    // run window, then compare on test_done. Optionally drives a store in the
    // RESULT cycle. Returns one cycle after RESULT.
    task automatic run_test(input int idx, input bit rs,
                            input logic [AW-1:0] ra, input logic [DW-1:0] rd);
        exp_t e;
        exp_t g;
        bit   hitm;
        int   n;
        hitm  = 1'b0;
        e.mmv = 1'b0;
        e.mma = '0;
        e.mmd = '0;
        foreach (evs[i]) begin
            if (evs[i].kind == 0) begin
                if (evs[i].adr == m_adr[idx] && evs[i].dat == m_dat[idx]) hitm = 1'b1;
                else if (!e.mmv) begin
                    e.mmv = 1'b1;
                    e.mma = evs[i].adr;
                    e.mmd = evs[i].dat;
                end
            end
        end
`ifndef SEQ_MISMATCH_LOG_EN
        e.mmv = 1'b0;
        e.mma = '0;
        e.mmd = '0;
`endif
        if (hitm) m_pc++;
        else      m_fc++;
        e.pass = hitm;
        e.pc   = CW'(m_pc);
        e.fc   = CW'(m_fc);
        e.idx  = IW'(idx);
        sb.push_back(e);

        n = 0;
        while (core_bus.dut_reset === 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("run_entry_dut_reset", core_bus.dut_reset, 0);

        for (int c = 0; c < WIN; c++) begin
            core_bus.memwrite = 1'b0;
            cfg_we            = 1'b0;
            start             = 1'b0;
            foreach (evs[i]) begin
                if (evs[i].cyc == c) begin
                    case (evs[i].kind)
                        0: begin
                            core_bus.memwrite  = 1'b1;
                            core_bus.dataadr   = evs[i].adr;
                            core_bus.writedata = evs[i].dat;
                        end
                        1: begin
                            cfg_we   = 1'b1;
                            cfg_idx  = IW'(evs[i].idx);
                            cfg_adr  = evs[i].adr;
                            cfg_data = evs[i].dat;
                        end
                        default: start = 1'b1;
                    endcase
                end
            end
            tick();
        end
        core_bus.memwrite = 1'b0;
        cfg_we            = 1'b0;
        start             = 1'b0;
        evs.delete();

        check("test_done_on_time", test_done, 1);
        n = 0;
        while (test_done !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        if (last_done >= 0) check("test_done_spacing", int'(cyc_cnt) - last_done, PERIOD);
        last_done = int'(cyc_cnt);

        g = sb.pop_front();
        check("test_pass", test_pass, g.pass);
        check("pass_count", pass_count, g.pc);
        check("fail_count", fail_count, g.fc);
        check("test_idx", test_idx, g.idx);
        check("result_dut_reset", core_bus.dut_reset, 1);
        check("mm_valid", mm_valid, g.mmv);
        check("mm_adr", mm_adr, g.mma);
        check("mm_data", mm_data, g.mmd);

        if (rs) begin
            core_bus.memwrite  = 1'b1;
            core_bus.dataadr   = ra;
            core_bus.writedata = rd;
        end
        tick();
        core_bus.memwrite = 1'b0;
    endtask

    task automatic finish_run(input bit last_pass);
        check("done_all_done", all_done, 1);
        check("done_test_idx", test_idx, NT - 1);
        check("done_dut_reset", core_bus.dut_reset, 1);
        check("done_strobe_low", test_done, 0);
        check("done_pass_count", pass_count, m_pc);
        check("done_fail_count", fail_count, m_fc);
        check("done_pass_held", test_pass, last_pass);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_dut_reset"}, core_bus.dut_reset, 1);
        check({tag, "_test_idx"}, test_idx, 0);
        check({tag, "_test_done"}, test_done, 0);
        check({tag, "_test_pass"}, test_pass, 0);
        check({tag, "_pass_count"}, pass_count, 0);
        check({tag, "_fail_count"}, fail_count, 0);
        check({tag, "_all_done"}, all_done, 0);
        check({tag, "_mm_valid"}, mm_valid, 0);
        check({tag, "_mm_adr"}, mm_adr, 0);
        check({tag, "_mm_data"}, mm_data, 0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        reset_n            = 1'b0;
        start              = 1'b0;
        cfg_we             = 1'b0;
        cfg_idx            = '0;
        cfg_adr            = '0;
        cfg_data           = '0;
        core_bus.memwrite  = 1'b0;
        core_bus.dataadr   = '0;
        core_bus.writedata = '0;
        for (int i = 0; i < NT; i++) begin
            m_adr[i] = '0;
            m_dat[i] = '0;
        end
        m_pc      = 0;
        m_fc      = 0;
        last_done = -1;

        repeat (2) @(posedge clk);
        #1;
        check_reset_values("por");
        reset_n = 1'b1;
        tick();

        cfg_write(0, 32'h14, 32'd21);
        cfg_write(1, 32'h54, 32'd7);
        cfg_write(2, 32'h0, 32'd3500);
        cfg_write(3, 32'hdead, 32'd1);

        // Run 1: tests 0 and 2 match; test 1 sees only a mismatch, plus a
        // cfg write and a start pulse mid-window that must both be ignored
        start_run();
        add_ev(0, 10, 0, 32'h14, 32'd21);
        run_test(0, 1'b0, '0, '0);
        add_ev(1, 20, 1, 32'h54, 32'd8);
        add_ev(0, 30, 0, 32'h54, 32'd8);
        add_ev(2, 40, 0, '0, '0);
        run_test(1, 1'b0, '0, '0);
        add_ev(0, 5, 0, 32'h0, 32'd3499);
        add_ev(0, 50, 0, 32'h0, 32'd3500);
        add_ev(0, 60, 0, 32'h4, 32'd1);
        run_test(2, 1'b0, '0, '0);
        finish_run(1'b1);

        // Run 2 (from DONE): wrong data, store on the last window cycle,
        // and a matching store only in the RESULT cycle
        start_run();
        add_ev(0, 10, 0, 32'h14, 32'd20);
        run_test(0, 1'b0, '0, '0);
        add_ev(0, WIN - 1, 0, 32'h54, 32'd7);
        run_test(1, 1'b0, '0, '0);
        run_test(2, 1'b1, 32'h0, 32'd3500);
        finish_run(1'b0);

        // Run 3: asynchronous reset in the middle of test 1
        start_run();
        add_ev(0, 10, 0, 32'h14, 32'd21);
        run_test(0, 1'b0, '0, '0);
        n = 0;
        while (core_bus.dut_reset === 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("abort_in_run", test_idx, 1);
        repeat (30) tick();
        #2 reset_n = 1'b0;
        #1;
        check_reset_values("async");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < NT; i++) begin
            m_adr[i] = '0;
            m_dat[i] = '0;
        end

        // Run 4: table was cleared by reset, so only zero stores match
        start_run();
        add_ev(0, 10, 0, 32'h14, 32'd21);
        run_test(0, 1'b0, '0, '0);
        add_ev(0, 10, 0, 32'h0, 32'd0);
        run_test(1, 1'b0, '0, '0);
        add_ev(0, WIN - 1, 0, 32'h0, 32'd0);
        run_test(2, 1'b0, '0, '0);
        finish_run(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
